// File: rtl/ltsm_reset_state_pkg.sv
// Shared LTSM definitions used by the RESET-state controller and its residency timer.
package ltsm_reset_state_pkg;

  typedef enum logic [1:0] {
    RST_IDLE      = 2'd0,
    RST_HOLD      = 2'd1,
    RST_WAIT_TRIG = 2'd2,
    RST_DONE      = 2'd3
  } ltsm_reset_state_t;

  // 4 ms at 100 MHz
  localparam int LTSM_RESET_MIN_CYCLES_4MS      = 400000;
  localparam int LTSM_RESET_RETRY_LIMIT_DEFAULT = 8;

  function automatic logic ltsm_exit_ready(
    input logic pll_locked,
    input logic supply_stable,
    input logic start_training,
    input logic sb_pattern
  );
    return pll_locked & supply_stable & (start_training | sb_pattern);
  endfunction

endpackage

// File: rtl/ltsm_reset_state_residency_timer.sv
// ltsm_residency_timer: clear/enable cycle counter that saturates at COUNT-1 and flags expiry.
module ltsm_residency_timer #(
  parameter int COUNT = 16,
  parameter int WIDTH = 5
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [WIDTH-1:0] LP_LAST = WIDTH'(COUNT - 1);

  logic [WIDTH-1:0] r_cnt;
  logic             w_at_last;

  assign w_at_last = (r_cnt == LP_LAST);
  assign o_expired = w_at_last;

  // Holding at the last value keeps the counter from ever wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= {WIDTH{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {WIDTH{1'b0}};
    end else if (i_en && !w_at_last) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/ltsm_reset_state.sv
// LTSM RESET-state controller: residency hold, readiness/trigger wait, entry counting.
// Defining LTSM_RESET_RETRY_LIMIT_EN adds the RETRY_LIMIT parameter and link-fail lockout.
module ltsm_reset_state
  import ltsm_reset_state_pkg::*;
#(
  parameter int MIN_RESIDENCY_CYCLES = LTSM_RESET_MIN_CYCLES_4MS,
  parameter int CNT_W                = 19,
  parameter int RETRY_W              = 4
`ifdef LTSM_RESET_RETRY_LIMIT_EN
  ,
  parameter int RETRY_LIMIT          = LTSM_RESET_RETRY_LIMIT_DEFAULT
`endif
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  input  logic               enable_i,
  input  logic               pll_locked_i,
  input  logic               supply_stable_i,
  input  logic               start_training_i,
  input  logic               SB_RX_pattern_detected_i,
  input  logic               clear_retry_i,
  output logic               RESET_done_o,
  output logic               enable_SB_tx,
  output logic               enable_SB_rx,
  output logic               mainband_idle_o,
  output logic               reset_state_timeout_counter_o,
  output logic [RETRY_W-1:0] retry_count_o,
  output logic               link_fail_o
);

  ltsm_reset_state_t r_state;
  ltsm_reset_state_t w_next;

  logic               w_entry;
  logic               w_tmr_clr;
  logic               w_tmr_en;
  logic               w_expired;
  logic               w_link_block;
  logic               r_exit_seen;
  logic               r_done;
  logic               r_mb_idle;
  logic               r_sb_rx;
  logic               r_pulse;
  logic [RETRY_W-1:0] r_retry;
  logic [RETRY_W-1:0] w_retry_base;
  logic [RETRY_W-1:0] w_retry_next;

  assign w_entry   = (r_state == RST_IDLE) && enable_i;
  assign w_tmr_clr = (r_state != RST_HOLD) || !enable_i;
  assign w_tmr_en  = (r_state == RST_HOLD);

  ltsm_residency_timer #(
    .COUNT (MIN_RESIDENCY_CYCLES),
    .WIDTH (CNT_W)
  ) u_residency_timer (
    .i_clk     (clk_100MHz),
    .i_rst_n   (reset),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_state <= RST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (!enable_i) begin
      w_next = RST_IDLE;
    end else begin
      case (r_state)
        RST_IDLE: begin
          w_next = RST_HOLD;
        end
        RST_HOLD: begin
          if (w_expired) begin
            w_next = RST_WAIT_TRIG;
          end else begin
            w_next = RST_HOLD;
          end
        end
        RST_WAIT_TRIG: begin
          if (r_exit_seen && !w_link_block) begin
            w_next = RST_DONE;
          end else begin
            w_next = RST_WAIT_TRIG;
          end
        end
        RST_DONE: begin
          w_next = RST_DONE;
        end
        default: begin
          w_next = RST_IDLE;
        end
      endcase
    end
  end

  // The exit condition is only captured while waiting, so triggers seen during HOLD are dropped.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_exit_seen <= 1'b0;
    end else if (enable_i && (r_state == RST_WAIT_TRIG)) begin
      r_exit_seen <= ltsm_exit_ready(pll_locked_i, supply_stable_i,
                                     start_training_i, SB_RX_pattern_detected_i);
    end else begin
      r_exit_seen <= 1'b0;
    end
  end

  // Clear takes effect before the entry increment, so a coincident clear leaves the count at 1.
  always_comb begin
    w_retry_base = r_retry;
    w_retry_next = r_retry;
    if (clear_retry_i) begin
      w_retry_base = {RETRY_W{1'b0}};
    end else begin
      w_retry_base = r_retry;
    end
    if (w_entry && !(&w_retry_base)) begin
      w_retry_next = w_retry_base + RETRY_W'(1);
    end else begin
      w_retry_next = w_retry_base;
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_mb_idle <= 1'b0;
      r_sb_rx   <= 1'b0;
      r_done    <= 1'b0;
      r_pulse   <= 1'b0;
      r_retry   <= {RETRY_W{1'b0}};
    end else begin
      r_mb_idle <= (w_next != RST_IDLE);
      r_sb_rx   <= (w_next == RST_WAIT_TRIG) || (w_next == RST_DONE);
      r_done    <= (w_next == RST_DONE);
      r_pulse   <= w_entry;
      r_retry   <= w_retry_next;
    end
  end

`ifdef LTSM_RESET_RETRY_LIMIT_EN
  localparam int               LP_CMP_W       = RETRY_W + 1;
  localparam logic [RETRY_W:0] LP_RETRY_LIMIT = LP_CMP_W'(RETRY_LIMIT);

  logic r_link_fail;

  // Limit is judged on the count held before this entry's increment.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_link_fail <= 1'b0;
    end else if (clear_retry_i) begin
      r_link_fail <= 1'b0;
    end else if (w_entry && ({1'b0, r_retry} >= LP_RETRY_LIMIT)) begin
      r_link_fail <= 1'b1;
    end else begin
      r_link_fail <= r_link_fail;
    end
  end

  assign w_link_block = r_link_fail;
  assign link_fail_o  = r_link_fail;
`else
  assign w_link_block = 1'b0;
  assign link_fail_o  = 1'b0;
`endif

  assign RESET_done_o                  = r_done;
  assign enable_SB_tx                  = 1'b0;
  assign enable_SB_rx                  = r_sb_rx;
  assign mainband_idle_o               = r_mb_idle;
  assign reset_state_timeout_counter_o = r_pulse;
  assign retry_count_o                 = r_retry;

endmodule

// File: doc/ltsm_reset_state.md
# ltsm_reset_state

LTSM RESET-state controller, the stage directly downstream of the TRAINERROR state. The LTSM top enables it after TRAINERROR completes, or after power-up. It enforces the minimum RESET residency, keeps the mainband idle and the sideband transmitter off, and waits for local readiness plus a training trigger. It then raises `RESET_done_o` so the LTSM top can advance to SBINIT. It also counts RESET entries so that repeated TRAINERROR→RESET loops are visible.

## Interface
Parameters:
- `MIN_RESIDENCY_CYCLES`, default 400000: minimum clk_100MHz cycles held in RESET (4 ms).
- `CNT_W`, default 19: residency counter width; must satisfy 2^CNT_W > MIN_RESIDENCY_CYCLES.
- `RETRY_W`, default 4: entry-counter width.
- `RETRY_LIMIT`, default 8: entry count at which link failure is declared (macro only).

Ports:
- `clk_100MHz`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset.
- `enable_i`  in  1  level; high while the LTSM top is in RESET.
- `pll_locked_i`  in  1  local PLL locked.
- `supply_stable_i`  in  1  local supplies stable.
- `start_training_i`  in  1  level; local training request from adapter/management.
- `SB_RX_pattern_detected_i`  in  1  partner sideband clock pattern detected.
- `clear_retry_i`  in  1  single-cycle pulse; clears the entry counter.
- `RESET_done_o`  out  1  exit to SBINIT permitted.
- `enable_SB_tx`  out  1  sideband TX enable; always 0 in this block.
- `enable_SB_rx`  out  1  sideband RX enable, used for partner-pattern detection.
- `mainband_idle_o`  out  1  forces mainband lanes to hold/tristate.
- `reset_state_timeout_counter_o`  out  1  one-cycle pulse on RESET entry.
- `retry_count_o`  out  RETRY_W  saturating RESET-entry count.
- `link_fail_o`  out  1  retry limit reached (macro only; otherwise tied 0).

## Operation
- States: IDLE, HOLD, WAIT_TRIG, DONE.
- IDLE:
  - Outputs low except `retry_count_o`.
  - `enable_i`=1 → HOLD.
  - On the same edge: clear the residency counter, pulse `reset_state_timeout_counter_o`, and increment `retry_count_o`. The count saturates at all-ones.
- HOLD:
  - Counter increments every cycle.
  - When the counter reaches MIN_RESIDENCY_CYCLES−1 → WAIT_TRIG.
  - Triggers and readiness inputs are ignored while in HOLD.
- WAIT_TRIG:
  - Exit condition: `pll_locked_i & supply_stable_i & (start_training_i | SB_RX_pattern_detected_i)`.
  - When the condition is true → DONE.
- DONE:
  - `RESET_done_o`=1 and holds until `enable_i` falls.
  - Readiness inputs dropping in DONE are ignored.
- `enable_i`=0 in any state → IDLE on the next edge. The counter is cleared and `RESET_done_o` drops that edge.
- `mainband_idle_o`=1 in HOLD, WAIT_TRIG and DONE.
- `enable_SB_rx`=1 in WAIT_TRIG and DONE only.
- `clear_retry_i`:
  - Zeroes the entry counter.
  - If it coincides with an IDLE→HOLD entry, the counter ends at 1 (clear, then increment).
- Counter width: CNT_W bits. The counter never wraps, because the HOLD exit occurs first.

## Timing
- Reset values:
  - State: IDLE.
  - Residency counter: 0.
  - All outputs: 0.
- Asserting `reset` mid-operation returns the block immediately to IDLE and clears `retry_count_o`.
- All outputs are registered; no combinational input→output paths.
- Entry latency: `enable_i` sampled high at edge N gives the timeout pulse and the HOLD outputs after edge N.
- Minimum entry-to-done latency: MIN_RESIDENCY_CYCLES+2 edges, counted from the first edge sampling `enable_i` high, assuming the exit condition is already true.
- A trigger pulse that is present only during HOLD is lost. The trigger must be high in WAIT_TRIG.
- Asynchronous inputs are expected to be synchronized upstream; this block does not synchronize them.

## Configuration
- Macro: `LTSM_RESET_RETRY_LIMIT_EN`.
- Defined:
  - `link_fail_o` is set when `retry_count_o` ≥ RETRY_LIMIT at IDLE→HOLD entry.
  - While `link_fail_o`=1, WAIT_TRIG never exits, so `RESET_done_o` stays 0.
  - `link_fail_o` clears only on `clear_retry_i` or `reset`.
- Undefined:
  - `link_fail_o` is tied 0.
  - The entry counter remains status-only.

## Structure
- The shared LTSM package holds:
  - The `ltsm_reset_state_t` enum.
  - `LTSM_RESET_MIN_CYCLES_4MS` = 400000.
  - A default retry-limit constant.
- One sub-module, `ltsm_residency_timer`:
  - Clear/enable inputs; `expired` output.
  - Parameterized by count and width.
  - Reusable by the other LTSM states' timers.

## Test plan
- Timing: MIN_RESIDENCY_CYCLES=16, all readiness high, `start_training_i`=1, `enable_i` raised at edge 0 → `RESET_done_o` first high after edge 18; `reset_state_timeout_counter_o` high for exactly one cycle after edge 0.
- Readiness gating: `pll_locked_i`=0 until cycle 40 → WAIT_TRIG is held; done rises 2 edges after `pll_locked_i` rises.
- Early trigger: `SB_RX_pattern_detected_i` pulsed in HOLD only → no done. Pulsed in WAIT_TRIG → done follows; `enable_SB_rx`=1 throughout WAIT_TRIG.
- Abort: `enable_i` dropped at cycle 8 of HOLD, then re-raised → counter restarts; `retry_count_o` goes 1→2; done is delayed by a full residency.
- Reset: `reset` asserted mid-HOLD → all outputs 0 immediately, including `retry_count_o`.
- Retry limit (macro defined): RETRY_LIMIT=3, four entries → `link_fail_o`=1 and no done. Then `clear_retry_i` → `link_fail_o`=0 and `retry_count_o`=0.
